uart_cmd_host: RTL
==================

UART_CMD_HOST -- requirements
Module: uart_cmd_host

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 81, meaning HCLK cycles per UART bit; legal range 4..65535.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000, meaning read-response timeout in HCLK cycles; used only when the timeout feature is compiled in.
REQ-003 SHALL have port HCLK  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port HRESETn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  command request present.
REQ-006 SHALL have port req_ready  output  1  block accepts a request this cycle.
REQ-007 SHALL have port req_write  input  1  1 = write command, 0 = read command.
REQ-008 SHALL have port req_addr  input  32  target bus address.
REQ-009 SHALL have port req_wdata  input  32  write data, ignored for reads.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata  output  32  read data, held until the next rsp_valid.
REQ-012 SHALL have port rsp_err  output  1  framing error or timeout, qualified by rsp_valid.
REQ-013 SHALL have port TX  output  1  serial line to the bridge RX, idle high.
REQ-014 SHALL have port RX  input  1  serial line from the bridge TX, asynchronous.

Function
REQ-015 SHALL use 8N1 framing, LSB first; each TX byte is start(0), 8 data bits, stop(1), then exactly one idle bit-time before the next start.
REQ-016 SHALL assert req_ready only in state IDLE; a request is accepted when req_valid && req_ready, capturing req_write, req_addr and req_wdata.
REQ-017 SHALL transmit a write as 9 bytes: 0xA3, addr[7:0], addr[15:8], addr[23:16], addr[31:24], wdata[7:0] .. wdata[31:24].
REQ-018 SHALL transmit a read as 5 bytes: 0xA5, addr[7:0] .. addr[31:24], then receive 4 bytes assembled into rdata LSB-byte first.
REQ-019 SHALL implement states IDLE -> SEND -> (write: DONE; read: WAIT_RD -> DONE) -> IDLE, with DONE lasting exactly one cycle and driving rsp_valid.
REQ-020 SHALL drive TX low for the start bit on the cycle after acceptance; write rsp_valid SHALL assert on the cycle after the last idle bit-time of byte 9 ends.
REQ-021 SHALL synchronise RX through two flops; the receiver SHALL be armed only in WAIT_RD.
REQ-022 SHALL detect a start on a synchronised 1->0 edge, re-sample at CLKS_PER_BIT/2, and abort that byte silently if the line is high (glitch rejection).
REQ-023 SHALL sample data bits and the stop bit at bit centres; a stop bit sampled 0 SHALL end the read with rsp_err=1 and rsp_rdata unchanged.
REQ-024 SHALL raise the read rsp_valid one cycle after the stop bit of byte 4 is sampled as 1; rsp_rdata SHALL update on that same cycle.
REQ-025 SHALL ignore req_valid while not in IDLE; a request present on the DONE cycle SHALL be accepted no earlier than the following cycle.
REQ-026 SHALL ignore RX activity outside WAIT_RD.

Reset
REQ-027 SHALL, on HRESETn=0 sampled at a rising HCLK edge, enter IDLE with TX=1, req_ready=1 after release, rsp_valid=0, rsp_err=0, rsp_rdata=0, all counters 0.
REQ-028 SHALL abort any in-flight byte on reset mid-operation, drive TX=1 on the next edge, and emit no rsp_valid for the aborted command.

Configuration
REQ-029 SHALL, when UART_CMD_HOST_TIMEOUT_EN is defined, count cycles in WAIT_RD from entry and, on reaching TIMEOUT_CYCLES with no complete response, go to DONE with rsp_err=1.
REQ-030 SHALL, when UART_CMD_HOST_TIMEOUT_EN is undefined, contain no timeout counter; WAIT_RD then waits indefinitely (exit only by response, framing error or reset).

Structure
REQ-031 SHALL place the command opcodes (0xA3 write, 0xA5 read) and the state enum in package uart_cmd_pkg, shared with the bridge.
REQ-032 SHALL instantiate one sub-module uart_byte_rx (synchroniser, start detect, bit sampling, framing check); the TX shifter and the command FSM stay in uart_cmd_host.

Verification
REQ-033 SHALL cover: CLKS_PER_BIT=8, write addr=0x0000_0004 data=0x0000_0001 -> TX bytes A3 04 00 00 00 01 00 00 00, rsp_valid, rsp_err=0, 9*11*8 cycles after acceptance.
REQ-034 SHALL cover: read addr=0x18, bench UART model answers 78 56 34 12 -> TX A5 18 00 00 00, rsp_rdata=0x12345678, rsp_err=0.
REQ-035 SHALL cover: read with 3-cycle low RX glitch before the response -> glitch ignored, rsp_rdata correct.
REQ-036 SHALL cover: read response with byte 2 stop bit forced 0 -> rsp_valid with rsp_err=1, rsp_rdata unchanged.
REQ-037 SHALL cover: HRESETn low during byte 3 of a write -> TX=1 next edge, no rsp_valid, a subsequent write completes normally.
REQ-038 SHALL cover, with UART_CMD_HOST_TIMEOUT_EN and TIMEOUT_CYCLES=2000: read with silent RX -> rsp_valid, rsp_err=1 exactly 2000 cycles after WAIT_RD entry.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - opcodes, FSM state encodings and command byte mux shared with the UART bridge
package uart_cmd_pkg;

  localparam logic [7:0] OPC_WRITE = 8'hA3;
  localparam logic [7:0] OPC_READ  = 8'hA5;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RD, DONE} cmd_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Byte idx of an outgoing command: opcode, addr LSB..MSB, then wdata LSB..MSB.
  function automatic logic [7:0] cmd_byte(input logic write, input logic [31:0] addr,
                                          input logic [31:0] wdata, input logic [3:0] idx);
    logic [7:0] b;
    case (idx)
      4'd0:    b = write ? OPC_WRITE : OPC_READ;
      4'd1:    b = addr[7:0];
      4'd2:    b = addr[15:8];
      4'd3:    b = addr[23:16];
      4'd4:    b = addr[31:24];
      4'd5:    b = wdata[7:0];
      4'd6:    b = wdata[15:8];
      4'd7:    b = wdata[23:16];
      default: b = wdata[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - 8N1 byte receiver: RX synchroniser, glitch-filtered start detect, centre sampling, stop check
module uart_byte_rx
  import uart_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = 81
) (
  input  logic       i_clk,
  input  logic       i_resetn,
  input  logic       i_en,
  input  logic       i_rx,
  output logic       o_valid,
  output logic       o_err,
  output logic [7:0] o_data
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  rx_state_t     r_state;
  rx_state_t     w_next;
  logic          r_sync1, r_sync2, r_prev;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_data;
  logic          w_start_edge, w_tick_half, w_tick_full;

  assign w_start_edge = r_prev & ~r_sync2;
  assign w_tick_half  = (r_cnt == HALF_M1);
  assign w_tick_full  = (r_cnt == FULL_M1);
  assign o_data       = r_data;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) r_state <= RX_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!i_en) begin
      w_next = RX_IDLE;
    end else begin
      case (r_state)
        RX_IDLE:  if (w_start_edge) w_next = RX_START;
        RX_START: if (w_tick_half) w_next = r_sync2 ? RX_IDLE : RX_DATA;
        RX_DATA:  if (w_tick_full && r_bit == 3'd7) w_next = RX_STOP;
        RX_STOP:  if (w_tick_full) w_next = RX_IDLE;
        default:  w_next = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    o_valid = 1'b0;
    o_err   = 1'b0;
    if (i_en && r_state == RX_STOP && w_tick_full) begin
      o_valid = r_sync2;
      o_err   = ~r_sync2;
    end
  end

  // Idle-high reset on the synchroniser keeps reset release from looking like a start edge.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_data  <= '0;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (r_state == RX_IDLE || r_state != w_next || w_tick_full) r_cnt <= '0;
      else                                                         r_cnt <= r_cnt + 1'b1;
      if (r_state == RX_IDLE) begin
        r_bit <= '0;
      end else if (r_state == RX_DATA && w_tick_full) begin
        r_bit  <= r_bit + 1'b1;
        r_data <= {r_sync2, r_data[7:1]};
      end
    end
  end

endmodule

// File: rtl/uart_cmd_host.sv
// rtl/uart_cmd_host.sv - UART bus-command host: serialises read/write commands, collects read data.
// Optional read-response timeout enabled by defining UART_CMD_HOST_TIMEOUT_EN.
module uart_cmd_host
  import uart_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 81,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        TX,
  input  logic        RX
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  cmd_state_t    r_state;
  cmd_state_t    w_next;
  logic          r_write;
  logic [31:0]   r_addr, r_wdata, r_rdata;
  logic [23:0]   r_acc;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit, r_byte;
  logic [1:0]    r_rx_idx;
  logic          r_err;
  logic          w_bit_end, w_frame_end, w_last_byte, w_accept, w_rx_last;
  logic          w_rx_valid, w_rx_err, w_timeout;
  logic [7:0]    w_rx_data;
  logic [10:0]   w_frame;

  // Frame slots 0..10: start, data LSB first, stop, one idle bit before the next start.
  assign w_frame     = {2'b11, cmd_byte(r_write, r_addr, r_wdata, r_byte), 1'b0};
  assign w_bit_end   = (r_cnt == FULL_M1);
  assign w_frame_end = w_bit_end && (r_bit == 4'd10);
  assign w_last_byte = (r_byte == (r_write ? 4'd8 : 4'd4));
  assign w_accept    = (r_state == IDLE) && req_valid;
  assign w_rx_last   = w_rx_valid && (r_rx_idx == 2'd3);
  assign rsp_rdata   = r_rdata;
  assign rsp_err     = r_err;

  uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .i_clk    (HCLK),
    .i_resetn (HRESETn),
    .i_en     (r_state == WAIT_RD),
    .i_rx     (RX),
    .o_valid  (w_rx_valid),
    .o_err    (w_rx_err),
    .o_data   (w_rx_data)
  );

`ifdef UART_CMD_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_to_cnt;
  always_ff @(posedge HCLK) begin
    if (!HRESETn || r_state != WAIT_RD) r_to_cnt <= '0;
    else                                r_to_cnt <= r_to_cnt + 1'b1;
  end
  assign w_timeout = (r_state == WAIT_RD) && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge HCLK) begin
    if (!HRESETn) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_next = SEND;
      SEND:    if (w_frame_end && w_last_byte) w_next = r_write ? DONE : WAIT_RD;
      WAIT_RD: if (w_rx_err || w_timeout || w_rx_last) w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (r_state == IDLE);
    rsp_valid = (r_state == DONE);
    TX        = (r_state == SEND) ? w_frame[r_bit] : 1'b1;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_byte   <= '0;
      r_rx_idx <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (r_state != SEND || w_bit_end) r_cnt <= '0;
      else                              r_cnt <= r_cnt + 1'b1;
      if (r_state != SEND) begin
        r_bit  <= '0;
        r_byte <= '0;
      end else if (w_frame_end) begin
        r_bit  <= '0;
        r_byte <= r_byte + 1'b1;
      end else if (w_bit_end) begin
        r_bit  <= r_bit + 1'b1;
      end
      if (r_state != WAIT_RD) begin
        r_rx_idx <= '0;
      end else if (w_rx_valid) begin
        r_rx_idx <= r_rx_idx + 1'b1;
        r_acc    <= {w_rx_data, r_acc[23:8]};
      end
      // A framing error or timeout leaves the previous read data visible.
      if (r_state != DONE && w_next == DONE) begin
        if (r_state == WAIT_RD && w_rx_last) begin
          r_rdata <= {w_rx_data, r_acc};
          r_err   <= 1'b0;
        end else begin
          r_err   <= (r_state == WAIT_RD);
        end
      end
    end
  end

endmodule
